// File: rtl/rf_wb_sched.sv
// Writeback scheduler: round-robin arbitration onto the single
// register file write port plus the per-register busy scoreboard.
module rf_wb_sched #(
  parameter int DW   = 32,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  output logic              iss_ok,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic [NREQ-1:0]   wb_valid,
  input  logic [NREQ*5-1:0] wb_rd,
  input  logic [NREQ*DW-1:0] wb_data,
  output logic [NREQ-1:0]   wb_ready,
  output logic              rf_wr_en,
  output logic [4:0]        rf_rd_addr,
  output logic [DW-1:0]     rf_rd_data,
  output logic [31:0]       busy,
  output logic              wb_unexp
);

  localparam int PW = (NREQ > 2) ? 2 : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] ptr_n;
  logic          gany;
  int            j;
  logic [4:0]    sel_rd;
  logic [DW-1:0] sel_data;
  logic [31:0]   set_v;
  logic [31:0]   clr_v;
  logic [31:0]   busy_n;
  logic          bad_wb;

  // First valid requester at or after ptr, wrapping
  always_comb begin
    gany = 1'b0;
    gidx = '0;
    j    = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gany && wb_valid[j]) begin
        gany = 1'b1;
        gidx = PW'(j);
      end
    end
  end

  always_comb begin
    wb_ready = '0;
    if (gany) wb_ready[gidx] = 1'b1;
  end

  assign ptr_n = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

  assign sel_rd   = wb_rd[int'(gidx)*5 +: 5];
  assign sel_data = wb_data[int'(gidx)*DW +: DW];

  assign iss_ok   = (iss_rd == 5'd0) || !busy[iss_rd];
  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

  assign bad_wb = gany && (sel_rd != 5'd0) && !busy[sel_rd];

  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_valid && iss_ok && iss_rd != 5'd0)
      set_v[iss_rd] = 1'b1;
    if (rf_wr_en)
      clr_v[rf_rd_addr] = 1'b1;
  end

  // Set applied after clear so a new producer keeps ownership
  assign busy_n = (busy & ~clr_v) | set_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      busy       <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
      wb_unexp   <= 1'b0;
    end else begin
      busy     <= {busy_n[31:1], 1'b0};
      rf_wr_en <= 1'b0;
      if (gany) begin
        ptr        <= ptr_n;
        rf_wr_en   <= (sel_rd != 5'd0);
        rf_rd_addr <= sel_rd;
        rf_rd_data <= sel_data;
      end
      if (bad_wb) wb_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched; expected register file writes are
// queued by the stimulus and checked by an independent monitor.
module tb_rf_wb_sched;

  localparam int DW   = 32;
  localparam int NREQ = 2;

  logic              clk;
  logic              rst;
  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic              iss_ok;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [NREQ-1:0]   wb_valid;
  logic [NREQ*5-1:0] wb_rd;
  logic [NREQ*DW-1:0] wb_data;
  logic [NREQ-1:0]   wb_ready;
  logic              rf_wr_en;
  logic [4:0]        rf_rd_addr;
  logic [DW-1:0]     rf_rd_data;
  logic [31:0]       busy;
  logic              wb_unexp;

  int n_chk;
  int n_fail;
  logic [36:0] exp_q[$];

  rf_wb_sched #(.DW(DW), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .iss_ok     (iss_ok),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_ready   (wb_ready),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .busy       (busy),
    .wb_unexp   (wb_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] rd,
                         input logic [31:0] d);
    wb_rd[5*i +: 5]     = rd;
    wb_data[DW*i +: DW] = d;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1;
    iss_rd    = rd;
    cyc();
    iss_valid = 1'b0;
  endtask

  // Monitor: every register file write must match the queue head
  always @(negedge clk) begin
    logic [36:0] e;
    if (!rst && rf_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0h, none queued",
                 rf_rd_addr, rf_rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("mon_addr", 64'(rf_rd_addr), 64'(e[36:32]));
        chk("mon_data", 64'(rf_rd_data), 64'(e[31:0]));
      end
    end
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    iss_valid = 1'b0;
    iss_rd    = '0;
    rs1_addr  = '0;
    rs2_addr  = '0;
    wb_valid  = '1;
    wb_rd     = '0;
    wb_data   = '0;
    set_req(0, 5'd3, 32'h11);
    set_req(1, 5'd4, 32'h22);
    repeat (3) cyc();

    // Reset release with both requesters valid
    rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_wr_en", 64'(rf_wr_en), 64'h0);
    chk("rst_unexp", 64'(wb_unexp), 64'h0);
    chk("rst_addr", 64'(rf_rd_addr), 64'h0);
    chk("rst_ready", 64'(wb_ready), 64'b01);
    wb_valid = '0;
    cyc();

    // Basic writeback to x5
    iss_valid = 1'b1;
    iss_rd    = 5'd5;
    #1;
    chk("basic_iss_ok", 64'(iss_ok), 64'h1);
    cyc();
    iss_valid = 1'b0;
    rs1_addr  = 5'd5;
    #1;
    chk("basic_busy_set", 64'(busy), 64'h20);
    chk("basic_rs1_busy", 64'(rs1_busy), 64'h1);
    set_req(0, 5'd5, 32'hDEADBEEF);
    wb_valid = 2'b01;
    expect_wr(5'd5, 32'hDEADBEEF);
    #1;
    chk("basic_ready", 64'(wb_ready), 64'b01);
    cyc();
    wb_valid = '0;
    #1;
    chk("basic_wr_en", 64'(rf_wr_en), 64'h1);
    chk("basic_addr", 64'(rf_rd_addr), 64'h5);
    chk("basic_data", 64'(rf_rd_data), 64'hDEADBEEF);
    chk("basic_busy_t1", 64'(busy[5]), 64'h1);
    cyc();
    iss_rd = 5'd5;
    #1;
    chk("basic_busy_t2", 64'(busy[5]), 64'h0);
    chk("basic_rs1_clr", 64'(rs1_busy), 64'h0);
    chk("basic_iss_ok2", 64'(iss_ok), 64'h1);

    // Fairness: pointer now at 1, so grants go 1,0,1,0
    issue(5'd10);
    issue(5'd11);
    issue(5'd13);
    issue(5'd14);
    chk("fair_busy", 64'(busy), 64'h6C00);
    set_req(0, 5'd10, 32'hA1);
    set_req(1, 5'd11, 32'hB1);
    wb_valid = 2'b11;
    #1;
    chk("fair_g0", 64'(wb_ready), 64'b10);
    expect_wr(5'd11, 32'hB1);
    cyc();
    set_req(1, 5'd14, 32'hB2);
    #1;
    chk("fair_g1", 64'(wb_ready), 64'b01);
    expect_wr(5'd10, 32'hA1);
    cyc();
    set_req(0, 5'd13, 32'hA2);
    #1;
    chk("fair_g2", 64'(wb_ready), 64'b10);
    expect_wr(5'd14, 32'hB2);
    cyc();
    wb_valid = 2'b01;
    #1;
    chk("fair_g3", 64'(wb_ready), 64'b01);
    expect_wr(5'd13, 32'hA2);
    cyc();
    wb_valid = '0;
    cyc();
    chk("fair_busy_clr", 64'(busy), 64'h0);
    chk("fair_unexp", 64'(wb_unexp), 64'h0);

    // Hazards on x7
    issue(5'd7);
    rs1_addr = 5'd7;
    rs2_addr = 5'd8;
    iss_rd   = 5'd7;
    #1;
    chk("haz_rs1", 64'(rs1_busy), 64'h1);
    chk("haz_rs2", 64'(rs2_busy), 64'h0);
    chk("haz_iss_ok", 64'(iss_ok), 64'h0);
    iss_valid = 1'b1;
    cyc();
    chk("haz_busy_hold", 64'(busy), 64'h80);
    iss_rd = 5'd0;
    #1;
    chk("haz_x0_ok", 64'(iss_ok), 64'h1);
    cyc();
    iss_valid = 1'b0;
    chk("haz_x0_busy", 64'(busy), 64'h80);

    // Writeback to x0: accepted, no write, no error
    set_req(1, 5'd0, 32'h55);
    wb_valid = 2'b10;
    #1;
    chk("x0_ready", 64'(wb_ready), 64'b10);
    cyc();
    wb_valid = '0;
    #1;
    chk("x0_wr_en", 64'(rf_wr_en), 64'h0);
    chk("x0_unexp", 64'(wb_unexp), 64'h0);

    // Unexpected writeback to non-busy x12
    set_req(0, 5'd12, 32'h1);
    wb_valid = 2'b01;
    expect_wr(5'd12, 32'h1);
    #1;
    chk("unx_ready", 64'(wb_ready), 64'b01);
    cyc();
    wb_valid = '0;
    #1;
    chk("unx_wr_en", 64'(rf_wr_en), 64'h1);
    chk("unx_flag", 64'(wb_unexp), 64'h1);
    chk("unx_busy", 64'(busy), 64'h80);

    // Clear and set of x9 in the same cycle: set wins
    set_req(1, 5'd9, 32'h99);
    wb_valid = 2'b10;
    expect_wr(5'd9, 32'h99);
    cyc();
    wb_valid  = '0;
    iss_valid = 1'b1;
    iss_rd    = 5'd9;
    #1;
    chk("sc_wr_en", 64'(rf_wr_en), 64'h1);
    chk("sc_iss_ok", 64'(iss_ok), 64'h1);
    cyc();
    iss_valid = 1'b0;
    chk("sc_busy", 64'(busy), 64'h280);
    repeat (3) cyc();
    chk("unx_sticky", 64'(wb_unexp), 64'h1);

    // Reset beats a concurrent issue and transfer
    rst       = 1'b1;
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    set_req(0, 5'd3, 32'h33);
    wb_valid  = 2'b01;
    cyc();
    rst       = 1'b0;
    iss_valid = 1'b0;
    wb_valid  = '0;
    #1;
    chk("rst2_busy", 64'(busy), 64'h0);
    chk("rst2_unexp", 64'(wb_unexp), 64'h0);
    chk("rst2_wr_en", 64'(rf_wr_en), 64'h0);
    chk("rst2_data", 64'(rf_rd_data), 64'h0);
    cyc();
    cyc();
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
